// File: rtl/display_pkg.sv
// Shared constants for the display arbiter slice: pixel width, FSM encoding
// and the default burst length.
package display_pkg;

   localparam int RGB_W         = 24;
   localparam int BURST_LEN_DEF = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GNT0 = 2'd1;
   localparam logic [1:0] ST_GNT1 = 2'd2;

   typedef logic [RGB_W-1:0] rgb_t;

   // One-hot grant vector for a state; IDLE (and any illegal code) maps to 2'b00.
   function automatic logic [1:0] state_grant(input logic [1:0] state);
      return {state == ST_GNT1, state == ST_GNT0};
   endfunction

endpackage

// File: rtl/display_rr_sel.sv
// Grant decision for the two-source display arbiter: idle tie-break against
// the last grant, and burst-end / valid-drop rotation out of a grant.
module display_rr_sel
   import display_pkg::*;
(
   input  logic [1:0] state,
   input  logic       last_grant,
   input  logic       src0_valid,
   input  logic       src1_valid,
   input  logic       burst_end,
   output logic [1:0] next_state,
   output logic       grant_exit
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      next_state = state;
      grant_exit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (src0_valid && src1_valid)
               next_state = last_grant ? ST_GNT0 : ST_GNT1;
            else if (src0_valid)
               next_state = ST_GNT0;
            else if (src1_valid)
               next_state = ST_GNT1;
         end
         ST_GNT0: begin
            if (burst_end || !src0_valid) begin
               grant_exit = 1'b1;
               if (src1_valid)       next_state = ST_GNT1;
               else if (!src0_valid) next_state = ST_IDLE;
               else                  next_state = ST_GNT0;
            end
         end
         ST_GNT1: begin
            if (burst_end || !src1_valid) begin
               grant_exit = 1'b1;
               if (src0_valid)       next_state = ST_GNT0;
               else if (!src1_valid) next_state = ST_IDLE;
               else                  next_state = ST_GNT1;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/display_arbiter.sv
// Two-source pixel arbiter in front of the display driver: bounded bursts,
// round-robin rotation, one-deep output register and per-source pixel counters.
module display_arbiter
   import display_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RGB_W-1:0] src0_rgb,
   input  logic [RGB_W-1:0] src1_rgb,
   input  logic             src0_valid,
   input  logic             src1_valid,
   output logic             src0_ready,
   output logic             src1_ready,
   output logic [RGB_W-1:0] drv_rgb,
   output logic             drv_valid,
   input  logic             drv_ready,
   output logic [1:0]       grant,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic             busy
);

   logic [1:0] state;
   logic [1:0] next_state;
   logic       last_grant;
   logic       grant_exit;
   logic [7:0] burst_cnt;
   logic       accept_ok;
   logic       xfer0;
   logic       xfer1;
   logic       burst_end;

   // Only new acceptance waits on the driver; a held pixel never blocks rotation.
   assign accept_ok  = !rst && (!drv_valid || drv_ready);
   assign src0_ready = (state == ST_GNT0) && accept_ok;
   assign src1_ready = (state == ST_GNT1) && accept_ok;
   assign xfer0      = src0_valid && src0_ready;
   assign xfer1      = src1_valid && src1_ready;
   assign burst_end  = (xfer0 || xfer1) && (burst_cnt == 8'(BURST_LEN - 1));

   assign grant = state_grant(state);
   assign busy  = (state != ST_IDLE) || drv_valid;

   display_rr_sel u_rr_sel (
      .state      (state),
      .last_grant (last_grant),
      .src0_valid (src0_valid),
      .src1_valid (src1_valid),
      .burst_end  (burst_end),
      .next_state (next_state),
      .grant_exit (grant_exit)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         burst_cnt  <= '0;
      end else begin
         state <= next_state;
         if (grant_exit) last_grant <= (state == ST_GNT1);
         if (grant_exit || state == ST_IDLE)
            burst_cnt <= '0;
         else if (xfer0 || xfer1)
            burst_cnt <= burst_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drv_valid <= 1'b0;
         drv_rgb   <= '0;
      end else if (xfer0 || xfer1) begin
         drv_valid <= 1'b1;
         drv_rgb   <= xfer0 ? src0_rgb : src1_rgb;
      end else if (drv_ready) begin
         drv_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (xfer0 && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
         if (xfer1 && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
      end
   end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, meaning max pixels transferred per grant before forced rotation (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of per-source accepted-pixel counters.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports src0_rgb / src1_rgb  input  24  pixel from source 0 (adapted path) / source 1 (bypass/OSD), R[23:16] G[15:8] B[7:0].
REQ-006 SHALL have ports src0_valid / src1_valid  input  1  source pixel valid.
REQ-007 SHALL have ports src0_ready / src1_ready  output  1  source pixel accepted this cycle when valid also high.
REQ-008 SHALL have port drv_rgb  output  24  pixel to display_driver input_rgb.
REQ-009 SHALL have port drv_valid  output  1  pixel to display_driver valid.
REQ-010 SHALL have port drv_ready  input  1  display_driver accepts drv_rgb this cycle.
REQ-011 SHALL have port grant  output  2  one-hot current grant, 2'b00 when idle.
REQ-012 SHALL have ports cnt0 / cnt1  output  CNT_W  accepted-pixel count per source, saturating.
REQ-013 SHALL have port busy  output  1  high when state != IDLE or drv_valid high.

Function
REQ-014 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-015 IDLE: both valid -> grant the source opposite last_grant; one valid -> grant it; none -> stay; new grant effective next cycle.
REQ-016 srcN_ready SHALL be high only in GNTN and when (!drv_valid || drv_ready); combinational, never high for the ungranted source.
REQ-017 Transfer on srcN = srcN_valid && srcN_ready; transferred pixel SHALL appear on drv_rgb with drv_valid high the next cycle (1-cycle latency).
REQ-018 drv_rgb/drv_valid SHALL hold stable while drv_valid && !drv_ready; cleared to drv_valid=0 after drv_ready with no new transfer.
REQ-019 Full throughput: with drv_ready held high and source valid continuous, one pixel per cycle.
REQ-020 burst_cnt SHALL reset to 0 on entering a grant and increment per transfer.
REQ-021 GNTN SHALL be left on the cycle the BURST_LEN-th transfer occurs, or when srcN_valid is low: go to GNT(other) if other valid, else IDLE if srcN_valid low, else re-enter GNTN with burst_cnt=0.
REQ-022 last_grant SHALL update to N whenever GNTN is exited.
REQ-023 Simultaneous burst-end and other-source valid SHALL rotate without an IDLE cycle.
REQ-024 cntN SHALL increment per transfer on srcN and saturate at all-ones.
REQ-025 Held pixel awaiting drv_ready SHALL not block grant rotation; only new acceptance is gated.

Reset
REQ-026 During rst: state IDLE, last_grant=1 (so source 0 wins first tie), burst_cnt=0, drv_valid=0, drv_rgb=24'h000000, cnt0=cnt1=0, grant=2'b00, srcN_ready=0.
REQ-027 rst mid-burst or with a pixel held SHALL discard the held pixel; no drv_valid in the cycle after rst deasserts.

Structure
REQ-028 Shared package display_pkg SHALL hold RGB_W=24, the FSM state encoding and the BURST_LEN default.
REQ-029 Grant decision (tie-break and rotation) SHALL reside in sub-module display_rr_sel; datapath, counters and FSM register in display_arbiter.

Verification
REQ-030 Reset then src0 single 24'hFF0000 with drv_ready=1 -> drv_rgb=FF0000, drv_valid one cycle, 1 cycle after transfer; cnt0=1.
REQ-031 Both sources continuous (src0 FF0000, src1 0000FF), BURST_LEN=4, drv_ready=1 -> 4 red, 4 blue, alternating, no idle gaps; source 0 first.
REQ-032 drv_ready=0 for 10 cycles with src0 FFFF00 valid -> drv_rgb held FFFF00, src0_ready=0, no second acceptance; on drv_ready=1 next pixel accepted same cycle.
REQ-033 src0 drops valid after 2 of 4 burst pixels while src1 valid -> grant 2'b10 next cycle.
REQ-034 rst asserted with drv_valid high mid-burst -> all outputs at reset values next cycle; first post-reset grant goes to source 0 on tie.
REQ-035 Force cnt1 to all-ones, transfer on src1 -> cnt1 stays all-ones.
